hist_bin_sequencer: RTL and testbench

Top-level controller for the histogram kernel and its bin RAM. Runs one job per `start` in four phases: clear every bin to zero, release the kernel from reset, wait for its `valid`, then stream all bin counts out on a ready/valid port. It owns the single bin-RAM port and muxes it between the clear engine, the kernel and the drain engine.

---
 rtl/hist_bin_sequencer_pkg.sv | 21 ++
 rtl/hist_bin_sequencer_if.sv | 31 +++
 rtl/hist_bin_port_mux.sv | 38 +++
 rtl/hist_bin_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hist_bin_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_bin_sequencer_pkg.sv
// Shared types and defaults for the histogram bin sequencer: state encoding,
// default geometry and the bin RAM read latency the drain path is built around.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_D_REQ,
    ST_D_CAP,
    ST_D_OUT
  } state_t;

  localparam int DEF_NUM_BINS = 256;
  localparam int DEF_BIN_AW   = 8;
  localparam int DEF_BIN_DW   = 32;

  // D_REQ -> D_CAP spacing assumes the RAM returns data one cycle after the address.
  localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/hist_bin_sequencer_if.sv
// Ready/valid stream carrying drained bin counts with their index and last flag.
interface hist_bin_sequencer_if
  import hist_pkg::*;
#(
  parameter int BIN_AW = DEF_BIN_AW,
  parameter int BIN_DW = DEF_BIN_DW
) ();

  logic              out_valid;
  logic              out_ready;
  logic [BIN_DW-1:0] out_data;
  logic [BIN_AW-1:0] out_bin;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_bin,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_bin,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/hist_bin_port_mux.sv
// Steers the single bin RAM port between the clear engine, the kernel and the
// drain engine, selected purely by the sequencer state.
module hist_bin_port_mux
  import hist_pkg::*;
#(
  parameter int BIN_AW = DEF_BIN_AW,
  parameter int BIN_DW = DEF_BIN_DW
) (
  input  state_t            state,
  input  logic [BIN_AW-1:0] idx,
  input  logic [BIN_AW-1:0] k_raddr,
  input  logic [BIN_AW-1:0] k_waddr,
  input  logic [BIN_DW-1:0] k_wdata,
  input  logic              k_wen,
  output logic [BIN_AW-1:0] bin_raddr,
  output logic [BIN_AW-1:0] bin_waddr,
  output logic [BIN_DW-1:0] bin_wdata,
  output logic              bin_wen
);

  always_comb begin
    bin_raddr = idx;
    bin_waddr = idx;
    bin_wdata = '0;
    bin_wen   = 1'b0;
    case (state)
      ST_CLEAR: bin_wen = 1'b1;
      ST_RUN: begin
        bin_raddr = k_raddr;
        bin_waddr = k_waddr;
        bin_wdata = k_wdata;
        bin_wen   = k_wen;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hist_bin_sequencer.sv
// Job sequencer for the histogram kernel: clear bins, run kernel, drain counts.
// Optional RUN-phase watchdog enabled by defining HIST_WDOG_EN.
module hist_bin_sequencer
  import hist_pkg::*;
#(
  parameter int NUM_BINS    = DEF_NUM_BINS,
  parameter int BIN_AW      = DEF_BIN_AW,
  parameter int BIN_DW      = DEF_BIN_DW,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              kernel_rst,
  input  logic              kernel_valid,
  input  logic [BIN_AW-1:0] k_raddr,
  input  logic [BIN_AW-1:0] k_waddr,
  input  logic [BIN_DW-1:0] k_wdata,
  input  logic              k_wen,
  output logic [BIN_DW-1:0] k_rdata,
  output logic [BIN_AW-1:0] bin_raddr,
  output logic [BIN_AW-1:0] bin_waddr,
  output logic [BIN_DW-1:0] bin_wdata,
  output logic              bin_wen,
  input  logic [BIN_DW-1:0] bin_rdata,
  hist_bin_sequencer_if.master drain
);

  // One extra index bit so a full 2**BIN_AW sweep ends without wrapping to 0.
  localparam logic [BIN_AW:0] LAST_IDX = (BIN_AW+1)'(NUM_BINS - 1);
  localparam logic [BIN_AW:0] IDX_ONE  = (BIN_AW+1)'(1);

  state_t            state_reg;
  logic [BIN_AW:0]   idx_reg;
  logic              kernel_rst_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              valid_reg;
  logic              last_reg;
  logic [BIN_DW-1:0] data_reg;
  logic [BIN_AW-1:0] bin_reg;

`ifdef HIST_WDOG_EN
  localparam int              WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  logic [WDOG_W-1:0] wdog_reg;
  logic              err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      kernel_rst_reg <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      last_reg       <= 1'b0;
      data_reg       <= '0;
      bin_reg        <= '0;
`ifdef HIST_WDOG_EN
      wdog_reg       <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg      <= ST_IDLE;
        kernel_rst_reg <= 1'b1;
        busy_reg       <= 1'b0;
        valid_reg      <= 1'b0;
        last_reg       <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              state_reg <= ST_CLEAR;
              idx_reg   <= '0;
              busy_reg  <= 1'b1;
`ifdef HIST_WDOG_EN
              err_reg   <= 1'b0;
`endif
            end
          end
          ST_CLEAR: begin
            idx_reg <= idx_reg + IDX_ONE;
            if (idx_reg == LAST_IDX) begin
              state_reg      <= ST_RUN;
              kernel_rst_reg <= 1'b0;
`ifdef HIST_WDOG_EN
              wdog_reg       <= '0;
`endif
            end
          end
          ST_RUN: begin
            if (kernel_valid) begin
              state_reg      <= ST_D_REQ;
              idx_reg        <= '0;
              kernel_rst_reg <= 1'b1;
            end
`ifdef HIST_WDOG_EN
            else if (wdog_reg == WDOG_LAST) begin
              state_reg      <= ST_IDLE;
              kernel_rst_reg <= 1'b1;
              busy_reg       <= 1'b0;
              err_reg        <= 1'b1;
            end else begin
              wdog_reg <= wdog_reg + WDOG_ONE;
            end
`endif
          end
          ST_D_REQ: state_reg <= ST_D_CAP;
          ST_D_CAP: begin
            data_reg  <= bin_rdata;
            bin_reg   <= idx_reg[BIN_AW-1:0];
            last_reg  <= (idx_reg == LAST_IDX);
            valid_reg <= 1'b1;
            state_reg <= ST_D_OUT;
          end
          ST_D_OUT: begin
            if (drain.out_ready) begin
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              if (last_reg) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end else begin
                idx_reg   <= idx_reg + IDX_ONE;
                state_reg <= ST_D_REQ;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  hist_bin_port_mux #(
    .BIN_AW (BIN_AW),
    .BIN_DW (BIN_DW)
  ) u_port_mux (
    .state     (state_reg),
    .idx       (idx_reg[BIN_AW-1:0]),
    .k_raddr   (k_raddr),
    .k_waddr   (k_waddr),
    .k_wdata   (k_wdata),
    .k_wen     (k_wen),
    .bin_raddr (bin_raddr),
    .bin_waddr (bin_waddr),
    .bin_wdata (bin_wdata),
    .bin_wen   (bin_wen)
  );

  assign k_rdata         = bin_rdata;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign kernel_rst      = kernel_rst_reg;
  assign drain.out_valid = valid_reg;
  assign drain.out_data  = data_reg;
  assign drain.out_bin   = bin_reg;
  assign drain.out_last  = last_reg;
`ifdef HIST_WDOG_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hist_bin_sequencer.sv
// Randomized self-checking bench for hist_bin_sequencer with a bin RAM model,
// a read-modify-write kernel model and an array-based expected histogram.
module tb_hist_bin_sequencer;
  import hist_pkg::*;

  localparam int NB = 256;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef HIST_WDOG_EN
  localparam int WD = 100;
`else
  localparam int WD = 65536;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          kernel_valid = 1'b0;
  logic [AW-1:0] k_raddr = '0;
  logic [AW-1:0] k_waddr = '0;
  logic [DW-1:0] k_wdata = '0;
  logic          k_wen = 1'b0;
  logic          busy, done, err, kernel_rst, bin_wen;
  logic [DW-1:0] k_rdata, bin_wdata, bin_rdata;
  logic [AW-1:0] bin_raddr, bin_waddr;
  logic          scramble = 1'b1;

  hist_bin_sequencer_if #(.BIN_AW(AW), .BIN_DW(DW)) drain_bus ();

  hist_bin_sequencer #(
    .NUM_BINS(NB), .BIN_AW(AW), .BIN_DW(DW), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .kernel_rst(kernel_rst),
    .kernel_valid(kernel_valid), .k_raddr(k_raddr), .k_waddr(k_waddr),
    .k_wdata(k_wdata), .k_wen(k_wen), .k_rdata(k_rdata),
    .bin_raddr(bin_raddr), .bin_waddr(bin_waddr), .bin_wdata(bin_wdata),
    .bin_wen(bin_wen), .bin_rdata(bin_rdata), .drain(drain_bus)
  );

  always #5 clk = ~clk;

  // Bin RAM: one write port, registered read, optionally filled with garbage.
  logic [DW-1:0] mem [NB];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NB; i++) mem[i] <= $urandom;
    end else if (bin_wen) begin
      mem[bin_waddr] <= bin_wdata;
    end
    bin_rdata <= mem[bin_raddr];
  end

  int total = 0;
  int bad = 0;
  int unsigned hist [NB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_and_clear();
    int clr;
    int addr_bad;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    clr = 0;
    addr_bad = 0;
    while (bin_wen === 1'b1 && clr < NB + 8) begin
      if (bin_waddr !== clr[AW-1:0] || bin_wdata !== '0) addr_bad++;
      clr++;
      tick();
    end
    chk("clear_cycles", clr, NB);
    chk("clear_addr_errs", addr_bad, 0);
    chk("run_kernel_rst", kernel_rst, 0);
  endtask

  task automatic run_job(input bit bp, input int abort_at, input bit spam, input int nops);
    int beats, dones, drain_cyc, b, inc;
    bit finished, last_acc, prev_stall, ready;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_bin;
    foreach (hist[i]) hist[i] = 0;
    start_and_clear();

    // Kernel model: read-modify-write increments through the passthrough port.
    for (int op = 0; op <= nops; op++) begin
      b   = (op == 0) ? 5 : int'($urandom_range(0, NB - 1));
      inc = (op == 0) ? 3 : int'($urandom_range(1, 100));
      k_wen   = 1'b0;
      k_raddr = b[AW-1:0];
      if (spam && op == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk("kernel_rdata", k_rdata, hist[b]);
      k_waddr = b[AW-1:0];
      k_wdata = k_rdata + DW'(inc);
      k_wen   = 1'b1;
      hist[b] += inc;
      #1;
      chk("run_wen_pass", bin_wen, 1);
      chk("run_waddr_pass", bin_waddr, b);
      tick();
    end
    k_wen = 1'b0;
    kernel_valid = 1'b1;
    tick();
    chk("drain_kernel_rst", kernel_rst, 1);

    beats = 0; dones = 0; drain_cyc = 0;
    finished = 0; last_acc = 0; prev_stall = 0;
    for (int cyc = 0; cyc < 10000 && !finished; cyc++) begin
      if (done === 1'b1) dones++;
      if (last_acc) begin
        start = 1'b0;
        drain_cyc = cyc;
        chk("done_pulse", done, 1);
        chk("done_idle", busy, 0);
        finished = 1;
      end else if (drain_bus.out_valid === 1'b1 && abort_at >= 0 && beats == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", drain_bus.out_valid, 0);
        chk("abort_kernel_rst", kernel_rst, 1);
        chk("abort_done", done, 0);
        finished = 1;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", drain_bus.out_valid, 1);
          chk("stall_data", drain_bus.out_data, hold_data);
          chk("stall_bin", drain_bus.out_bin, hold_bin);
        end
        ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
        drain_bus.out_ready = ready;
        prev_stall = 0;
        if (drain_bus.out_valid === 1'b1) begin
          if (ready) begin
            chk("beat_bin", drain_bus.out_bin, beats);
            chk("beat_data", drain_bus.out_data, hist[beats]);
            chk("beat_last", drain_bus.out_last, beats == NB - 1);
            if (beats == NB - 1) last_acc = 1;
            beats++;
          end else begin
            prev_stall = 1;
            hold_data  = drain_bus.out_data;
            hold_bin   = drain_bus.out_bin;
          end
        end
        if (spam) start = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    chk("drain_finished", finished, 1);
    if (!bp && abort_at < 0) chk("drain_cycles", drain_cyc, 3 * NB);
    kernel_valid = 1'b0;
    start = 1'b0;
    drain_bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("done_count", dones, (abort_at >= 0) ? 0 : 1);
    chk("post_job_busy", busy, 0);
  endtask

  initial begin
    drain_bus.out_ready = 1'b0;
    repeat (3) tick();
    scramble = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kernel_rst", kernel_rst, 1);
    chk("rst_out_valid", drain_bus.out_valid, 0);
    chk("rst_out_last", drain_bus.out_last, 0);
    chk("rst_bin_wen", bin_wen, 0);
    rst = 1'b0;
    tick();

    // Full job, no backpressure, on a garbage-filled RAM.
    run_job(1'b0, -1, 1'b0, 20);

    // Kernel signals in IDLE must not move the sequencer or reach the RAM.
    kernel_valid = 1'b1;
    k_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_kv_busy", busy, 0);
      chk("idle_kv_bin_wen", bin_wen, 0);
    end
    kernel_valid = 1'b0;
    k_wen = 1'b0;

    // Random 1-of-4 backpressure with start pulses during RUN and drain.
    run_job(1'b1, -1, 1'b1, 30);

    // Abort on drain beat 10, then a clean restart.
    run_job(1'b0, 10, 1'b0, 8);
    run_job(1'b0, -1, 1'b0, 8);

    // Reset in the middle of RUN.
    start_and_clear();
    k_waddr = 8'd3;
    k_wdata = 32'd7;
    k_wen   = 1'b1;
    rst     = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_kernel_rst", kernel_rst, 1);
    chk("midrst_bin_wen", bin_wen, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_out_valid", drain_bus.out_valid, 0);
    chk("midrst_out_last", drain_bus.out_last, 0);
    rst   = 1'b0;
    k_wen = 1'b0;
    tick();
    run_job(1'b0, -1, 1'b0, 5);

`ifdef HIST_WDOG_EN
    begin
      int run_cyc;
      int wd_dones;
      start_and_clear();
      run_cyc = 0;
      wd_dones = 0;
      while (kernel_rst === 1'b0 && run_cyc < 1000) begin
        run_cyc++;
        if (done === 1'b1) wd_dones++;
        tick();
      end
      chk("wdog_run_cycles", run_cyc, WD);
      chk("wdog_err", err, 1);
      chk("wdog_busy", busy, 0);
      chk("wdog_done", wd_dones + int'(done), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wdog_err_cleared", err, 0);
      chk("wdog_restart_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
